// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared constants for the HI/LO multiply/divide unit.
//   - op encodings (also imported by the EX-stage ALU decoder)
//   - FSM state enum
//   - operand width and iteration counter width
package muldiv_pkg;

  localparam int MD_WIDTH = 32;
  localparam int CNT_W    = $clog2(MD_WIDTH) + 1;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_hilo_abs_neg.sv
// abs_neg: combinational conditional two's-complement.
//   neg  : when high, dout = -din, otherwise dout = din
//   din  : W-bit input value
//   dout : W-bit result
// Used both to take operand magnitudes and to restore result signs.
module abs_neg #(
  parameter int W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  assign dout = neg ? (~din + 1'b1) : din;

endmodule

// File: rtl/muldiv_hilo.sv
// muldiv_hilo: iterative multiply/divide unit owning the HI/LO pair.
//   clk, reset        : clock, asynchronous active-high reset
//   start, op         : issue request (sampled in IDLE) and operation
//   srcA, srcB        : multiplicand/dividend, multiplier/divisor
//   busy, done        : operation in flight, one-cycle completion pulse
//   div_by_zero       : last completed divide had srcB == 0
//   rd_en, rd_sel     : mfhi/mflo request, 0 = LO / 1 = HI (also write select)
//   rd_data           : combinational HI or LO
//   wr_en, wr_data    : mthi/mtlo request and value
//   stall             : read/write request while busy
//   state_dbg         : current FSM state
// Handshake: start is a single-cycle request accepted only in IDLE (no
// ready output; the core stalls on busy). wr_en/rd_en are honoured when
// busy is low; while busy they raise stall and writes are dropped.
module muldiv_hilo
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  input  logic             rd_en,
  input  logic             rd_sel,
  output logic [WIDTH-1:0] rd_data,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             stall,
  output logic [1:0]       state_dbg
);

  localparam int W2 = 2 * WIDTH;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic             sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic [WIDTH-1:0] a_raw_q, a_raw_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic             done_q, done_d, dbz_q, dbz_d;

  // Operand conditioning at issue time
  logic             in_signed;
  logic [WIDTH-1:0] abs_a, abs_b;

  assign in_signed = (op == OP_MULT) || (op == OP_DIV);

  abs_neg #(.W(WIDTH)) u_abs_a (.neg(in_signed & srcA[WIDTH-1]), .din(srcA), .dout(abs_a));
  abs_neg #(.W(WIDTH)) u_abs_b (.neg(in_signed & srcB[WIDTH-1]), .din(srcB), .dout(abs_b));

  // One iteration step. acc holds {upper, lower}:
  //   multiply: upper = partial product, lower = remaining multiplier bits
  //   divide  : upper = partial remainder, lower = dividend bits / quotient
  logic             run_signed, run_div;
  logic [WIDTH:0]   mul_sum, rem_sh, trial;
  logic [W2-1:0]    mul_next, div_next;

  assign run_signed = (op_q == OP_MULT) || (op_q == OP_DIV);
  assign run_div    = (op_q == OP_DIVU) || (op_q == OP_DIV);

  assign mul_sum  = {1'b0, acc_q[W2-1:WIDTH]} + {1'b0, (acc_q[0] ? b_q : {WIDTH{1'b0}})};
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Remainder stays below the divisor, so the shifted value needs one extra bit.
  assign rem_sh   = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
  assign trial    = rem_sh - {1'b0, b_q};
  assign div_next = trial[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                 : {trial[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};

  // Sign correction applied in FINISH
  logic [W2-1:0]    prod_fix;
  logic [WIDTH-1:0] quot_fix, rem_fix;
  logic             neg_res;

  assign neg_res = run_signed & (sign_a_q ^ sign_b_q);

  abs_neg #(.W(W2))    u_fix_prod (.neg(neg_res), .din(acc_q), .dout(prod_fix));
  abs_neg #(.W(WIDTH)) u_fix_quot (.neg(neg_res), .din(acc_q[WIDTH-1:0]), .dout(quot_fix));
  abs_neg #(.W(WIDTH)) u_fix_rem  (.neg(run_signed & sign_a_q), .din(acc_q[W2-1:WIDTH]),
                                   .dout(rem_fix));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    a_raw_d  = a_raw_q;
    b_d      = b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    acc_d    = acc_q;
    done_d   = 1'b0;
    dbz_d    = dbz_q;
    case (state_q)
      IDLE: begin
        // An mthi/mtlo in the same cycle as start still lands; FINISH
        // later overwrites both registers.
        if (wr_en) begin
          if (rd_sel) hi_d = wr_data;
          else        lo_d = wr_data;
        end
        if (start) begin
          state_d  = RUN;
          cnt_d    = CNT_W'(WIDTH);
          op_d     = op;
          sign_a_d = in_signed & srcA[WIDTH-1];
          sign_b_d = in_signed & srcB[WIDTH-1];
          a_raw_d  = srcA;
          b_d      = abs_b;
          acc_d    = {{WIDTH{1'b0}}, abs_a};
          dbz_d    = 1'b0;
        end
      end
      RUN: begin
        acc_d = run_div ? div_next : mul_next;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = FINISH;
      end
      FINISH: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (run_div) begin
          if (b_q == {WIDTH{1'b0}}) begin
            lo_d  = {WIDTH{1'b1}};
            hi_d  = a_raw_q;
            dbz_d = 1'b1;
          end else begin
            lo_d = quot_fix;
            hi_d = rem_fix;
          end
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      a_raw_q  <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      acc_q    <= '0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      a_raw_q  <= a_raw_d;
      b_q      <= b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      acc_q    <= acc_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign rd_data     = rd_sel ? hi_q : lo_q;
  assign stall       = (rd_en | wr_en) & busy;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_muldiv_hilo.sv
// tb_muldiv_hilo: self-checking bench for muldiv_hilo. Expected HI/LO
// values come from plain 64-bit arithmetic on the operands.
module tb_muldiv_hilo;
  import muldiv_pkg::*;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] srcA, srcB;
  logic         busy, done, div_by_zero;
  logic         rd_en, rd_sel;
  logic [W-1:0] rd_data;
  logic         wr_en;
  logic [W-1:0] wr_data;
  logic         stall;
  logic [1:0]   state_dbg;

  always #5 clk = ~clk;

  muldiv_hilo #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .srcA(srcA), .srcB(srcB),
    .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .rd_en(rd_en), .rd_sel(rd_sel), .rd_data(rd_data),
    .wr_en(wr_en), .wr_data(wr_data), .stall(stall), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [2*W:0] exp_q[$];   // {dbz, hi, lo}

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: result of one operation from plain arithmetic.
  function automatic logic [2*W:0] model(input logic [1:0] o, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [63:0] up, tq, tr;
    longint      sa, sb, sq, sr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      OP_MULTU: begin
        up = {32'b0, a} * {32'b0, b};
        return {1'b0, up};
      end
      OP_MULT: begin
        sq = sa * sb;
        tq = sq;
        return {1'b0, tq};
      end
      OP_DIVU: begin
        if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        return {1'b0, a % b, a / b};
      end
      default: begin
        if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
        sq = sa / sb;
        sr = sa % sb;
        tq = sq;
        tr = sr;
        return {1'b0, tr[31:0], tq[31:0]};
      end
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic read_reg(input logic sel, output logic [W-1:0] val);
    rd_sel = sel;
    #1;
    val = rd_data;
  endtask

  // Issue one op; optionally an mthi/mtlo in the same IDLE cycle.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic do_wr, input logic wsel, input logic [W-1:0] wdat);
    logic [W-1:0] v;
    @(negedge clk);
    start = 1'b1; op = o; srcA = a; srcB = b;
    wr_en = do_wr; rd_sel = wsel; wr_data = wdat;
    exp_q.push_back(model(o, a, b));
    @(posedge clk);
    #1;
    start = 1'b0;
    wr_en = 1'b0;
    check("busy_after_start", busy, 1);
    check("done_dropped", done, 0);
    check("dbz_cleared_on_start", div_by_zero, 0);
    if (do_wr) begin
      read_reg(wsel, v);
      check("write_with_start", v, wdat);
    end
  endtask

  // Wait (bounded) for done; lat is the number of edges still expected.
  task automatic wait_done(input int lat);
    int           k;
    logic         got;
    logic [2*W:0] e;
    logic [W-1:0] v;
    k   = 0;
    got = 1'b0;
    while (k < lat + 8 && !got) begin
      @(posedge clk);
      #1;
      k++;
      if (done) got = 1'b1;
      else begin
        check("busy_in_flight", busy, 1);
        check("stall_in_flight", stall, rd_en | wr_en);
      end
    end
    check("done_latency", k, lat);
    check("busy_at_done", busy, 0);
    check("stall_at_done", stall, 0);
    if (exp_q.size() == 0) begin
      check("exp_queue_empty", 1, 0);
    end else begin
      e = exp_q.pop_front();
      read_reg(1'b0, v);
      check("lo_result", v, e[W-1:0]);
      read_reg(1'b1, v);
      check("hi_result", v, e[2*W-1:W]);
      check("div_by_zero", div_by_zero, e[2*W]);
    end
  endtask

  task automatic write_reg(input logic sel, input logic [W-1:0] d);
    logic [W-1:0] v;
    @(negedge clk);
    wr_en = 1'b1; rd_sel = sel; wr_data = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    read_reg(sel, v);
    check(sel ? "mthi" : "mtlo", v, d);
  endtask

  function automatic logic [W-1:0] pick_operand(input logic allow_zero);
    case ($urandom_range(0, 7))
      0: return allow_zero ? 32'h0 : 32'h1;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    logic [W-1:0] v;
    reset = 1'b1; start = 1'b0; op = 2'b00; srcA = '0; srcB = '0;
    rd_en = 1'b0; rd_sel = 1'b0; wr_en = 1'b0; wr_data = '0;

    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dbz", div_by_zero, 0);
    check("rst_state", state_dbg, 0);
    read_reg(1'b0, v); check("rst_lo", v, 0);
    read_reg(1'b1, v); check("rst_hi", v, 0);
    rd_en = 1'b1; #1; check("rst_stall", stall, 0); rd_en = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // Directed cases; each issue lands in the previous done cycle.
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0); wait_done(33);
    issue(OP_MULT,  32'hFFFF_FFFD, 32'd7,         0, 0, 0); wait_done(33);
    issue(OP_DIV,   32'hFFFF_FFF9, 32'd2,         0, 0, 0); wait_done(33);
    issue(OP_DIVU,  32'd100,       32'd0,         0, 0, 0); wait_done(33);
    issue(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0); wait_done(33);
    issue(OP_DIV,   32'h8000_0001, 32'd0,         0, 0, 0); wait_done(33);

    // Stall behaviour and ignored writes while busy.
    issue(OP_MULTU, 32'd5, 32'd6, 0, 0, 0);
    repeat (9) @(posedge clk);
    #1;
    rd_en = 1'b1; rd_sel = 1'b0;
    #1; check("stall_rd_busy", stall, 1);
    wr_en = 1'b1; wr_data = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("stall_wr_busy", stall, 1);
    end
    wr_en = 1'b0;
    wait_done(21);
    rd_en = 1'b0;
    write_reg(1'b0, 32'h1234_5678);
    write_reg(1'b1, 32'hCAFE_0001);

    // Async reset in the middle of a divide.
    issue(OP_DIVU, 32'd1000, 32'd7, 0, 0, 0);
    repeat (15) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("midop_rst_busy", busy, 0);
    check("midop_rst_done", done, 0);
    read_reg(1'b0, v); check("midop_rst_lo", v, 0);
    read_reg(1'b1, v); check("midop_rst_hi", v, 0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    issue(OP_DIVU, 32'd9, 32'd4, 0, 0, 0); wait_done(33);

    // Randomized ops, with occasional writes alongside or between them.
    for (int n = 0; n < 40; n++) begin
      logic [1:0]   o;
      logic [W-1:0] a, b;
      logic         wr_with;
      o = 2'($urandom_range(0, 3));
      a = pick_operand(1'b1);
      b = pick_operand(1'b1);
      wr_with = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 5) == 0) write_reg(1'($urandom_range(0, 1)), $urandom);
      issue(o, a, b, wr_with, 1'($urandom_range(0, 1)), $urandom);
      wait_done(33);
    end

    @(posedge clk);
    #1;
    check("final_done_low", done, 0);
    check("final_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
